// File: rtl/issue_queue_mp_if.sv
// Purpose: push/pop bus between the decode stage and the multi-port issue queue.
//   master : decode/issue side, drives the push data and the pop request,
//            observes the head window and the occupancy.
//   slave  : the queue itself.
// Signals:
//   in_data          push elements, slot 0 is the oldest
//   in_data_number   number of in_data slots to enqueue this cycle
//   out_data         head window, slot 0 is the head
//   out_valid        per-slot valid for out_data
//   out_data_number  number of head slots consumed this cycle
//   iq_size          current occupancy
//   iq_size_left     free entries
interface issue_queue_mp_if #(
  parameter int DEPTH  = 8,
  parameter int ELEM_W = 64,
  parameter int PUSH_W = 4,
  parameter int POP_W  = 2
);
  logic [PUSH_W*ELEM_W-1:0]       in_data;
  logic [$clog2(PUSH_W+1)-1:0]    in_data_number;
  logic [POP_W*ELEM_W-1:0]        out_data;
  logic [POP_W-1:0]               out_valid;
  logic [$clog2(POP_W+1)-1:0]     out_data_number;
  logic [$clog2(DEPTH+1)-1:0]     iq_size;
  logic [$clog2(DEPTH+1)-1:0]     iq_size_left;

  modport master (
    output in_data, in_data_number, out_data_number,
    input  out_data, out_valid, iq_size, iq_size_left
  );

  modport slave (
    input  in_data, in_data_number, out_data_number,
    output out_data, out_valid, iq_size, iq_size_left
  );
endinterface

// File: rtl/issue_queue_mp.sv
// Purpose: parametrised multi-port circular issue queue sitting between decode
//   and issue. Up to PUSH_W elements enter and up to POP_W elements leave per
//   cycle. Pushes are all-or-nothing against the start-of-cycle free space;
//   pops are clamped to the current occupancy. Sticky error flags and an
//   occupancy high-water mark are kept for debug.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   flush           discard all contents (beats stall and push/pop)
//   stall           freeze the queue, push and pop are ignored
//   q_if            push/pop bus (slave side), see issue_queue_mp_if
//   overflow_err    sticky, a push asked for more than the free space
//   underflow_err   sticky, a pop asked for more than the occupancy
//   high_water      largest occupancy seen since reset or flush
module issue_queue_mp #(
  parameter int DEPTH  = 8,
  parameter int ELEM_W = 64,
  parameter int PUSH_W = 4,
  parameter int POP_W  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       stall,
  issue_queue_mp_if.slave            q_if,
  output logic                       overflow_err,
  output logic                       underflow_err,
  output logic [$clog2(DEPTH+1)-1:0] high_water
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ELEM_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic [CNT_W-1:0]  size_left;
  logic [CNT_W-1:0]  push_req;
  logic [CNT_W-1:0]  pop_req;
  logic [CNT_W-1:0]  eff_push;
  logic [CNT_W-1:0]  eff_pop;
  logic [CNT_W-1:0]  count_next;
  logic              overflow_hit;
  logic              underflow_hit;

  // Request resolution. Push space is judged against the occupancy at the
  // start of the cycle, so a same-cycle pop never makes room for a push.
  always_comb begin
    size_left     = CNT_W'(DEPTH) - count;
    push_req      = CNT_W'(q_if.in_data_number);
    pop_req       = CNT_W'(q_if.out_data_number);
    underflow_hit = pop_req > count;
    eff_pop       = underflow_hit ? count : pop_req;
    overflow_hit  = push_req > size_left;
    eff_push      = overflow_hit ? '0 : push_req;
    count_next    = count - eff_pop + eff_push;
  end

  // Head window and occupancy come only from registered state, so there is
  // no combinational path from the request inputs to any output.
  always_comb begin
    q_if.out_data  = '0;
    q_if.out_valid = '0;
    for (int i = 0; i < POP_W; i++) begin
      q_if.out_data[i*ELEM_W +: ELEM_W] = mem[head + PTR_W'(i)];
      q_if.out_valid[i]                 = CNT_W'(i) < count;
    end
  end

  assign q_if.iq_size      = count;
  assign q_if.iq_size_left = size_left;

  // Queue state. Priority is reset, then flush, then stall, then push/pop.
  // Flush only rewinds the pointers; stale storage is hidden by count=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      high_water    <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      high_water <= '0;
    end else if (!stall) begin
      for (int k = 0; k < PUSH_W; k++) begin
        if (CNT_W'(k) < eff_push) begin
          mem[tail + PTR_W'(k)] <= q_if.in_data[k*ELEM_W +: ELEM_W];
        end
      end
      head  <= head + PTR_W'(eff_pop);
      tail  <= tail + PTR_W'(eff_push);
      count <= count_next;
      if (count_next > high_water) begin
        high_water <= count_next;
      end
      if (overflow_hit) begin
        overflow_err <= 1'b1;
      end
      if (underflow_hit) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_issue_queue_mp.sv
// Purpose: directed self-checking bench for issue_queue_mp with DEPTH=8,
//   PUSH_W=4, POP_W=2, ELEM_W=32. Each scenario task drives its own vectors
//   and compares the outputs against hand-computed values.
module tb_issue_queue_mp;

  localparam int DEPTH  = 8;
  localparam int ELEM_W = 32;
  localparam int PUSH_W = 4;
  localparam int POP_W  = 2;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       stall;
  logic       overflow_err;
  logic       underflow_err;
  logic [3:0] high_water;

  int checks = 0;
  int errors = 0;

  issue_queue_mp_if #(.DEPTH(DEPTH), .ELEM_W(ELEM_W), .PUSH_W(PUSH_W), .POP_W(POP_W)) bus ();

  issue_queue_mp #(.DEPTH(DEPTH), .ELEM_W(ELEM_W), .PUSH_W(PUSH_W), .POP_W(POP_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .stall         (stall),
    .q_if          (bus),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err),
    .high_water    (high_water)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Illegal request widths must never be driven by this bench.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (bus.in_data_number <= 3'(PUSH_W) && bus.out_data_number <= 2'(POP_W))
        else $error("[TB] illegal request width");
    end
  end

  function automatic logic [127:0] pack4(input logic [31:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  // Drive one cycle of requests just after a posedge, clock it in, then idle.
  task automatic cycle(input int push_n, input logic [127:0] data, input int pop_n,
                       input logic st, input logic fl);
    bus.in_data         = data;
    bus.in_data_number  = 3'(push_n);
    bus.out_data_number = 2'(pop_n);
    stall               = st;
    flush               = fl;
    @(posedge clk);
    #1;
    bus.in_data         = '0;
    bus.in_data_number  = '0;
    bus.out_data_number = '0;
    stall               = 1'b0;
    flush               = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0;
    bus.in_data = '0; bus.in_data_number = '0; bus.out_data_number = '0;
    #1;
    checks++; if (bus.iq_size !== 4'd0) begin errors++; $display("[TB] FAIL reset_size: got %0d expected 0", bus.iq_size); end
    checks++; if (bus.iq_size_left !== 4'd8) begin errors++; $display("[TB] FAIL reset_left: got %0d expected 8", bus.iq_size_left); end
    checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 00", bus.out_valid); end
    checks++; if (bus.out_data !== 64'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", bus.out_data); end
    checks++; if ({overflow_err, underflow_err} !== 2'b00) begin errors++; $display("[TB] FAIL reset_err: got %b expected 00", {overflow_err, underflow_err}); end
    checks++; if (high_water !== 4'd0) begin errors++; $display("[TB] FAIL reset_hw: got %0d expected 0", high_water); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_push_basic;
    cycle(4, pack4(32'h10, 32'h11, 32'h12, 32'h13), 0, 1'b0, 1'b0);
    checks++; if (bus.iq_size !== 4'd4) begin errors++; $display("[TB] FAIL push_size: got %0d expected 4", bus.iq_size); end
    checks++; if (bus.iq_size_left !== 4'd4) begin errors++; $display("[TB] FAIL push_left: got %0d expected 4", bus.iq_size_left); end
    checks++; if (bus.out_data !== 64'h00000011_00000010) begin errors++; $display("[TB] FAIL push_data: got %h expected 0000001100000010", bus.out_data); end
    checks++; if (bus.out_valid !== 2'b11) begin errors++; $display("[TB] FAIL push_valid: got %b expected 11", bus.out_valid); end
    checks++; if (high_water !== 4'd4) begin errors++; $display("[TB] FAIL push_hw: got %0d expected 4", high_water); end
  endtask

  task automatic test_push_pop_order;
    cycle(4, pack4(32'h20, 32'h21, 32'h22, 32'h23), 2, 1'b0, 1'b0);
    checks++; if (bus.iq_size !== 4'd6) begin errors++; $display("[TB] FAIL pp_size: got %0d expected 6", bus.iq_size); end
    checks++; if (bus.out_data !== 64'h00000013_00000012) begin errors++; $display("[TB] FAIL pp_data0: got %h expected 0000001300000012", bus.out_data); end
    cycle(0, '0, 2, 1'b0, 1'b0);
    checks++; if (bus.out_data !== 64'h00000021_00000020) begin errors++; $display("[TB] FAIL pp_data1: got %h expected 0000002100000020", bus.out_data); end
    checks++; if (bus.iq_size !== 4'd4) begin errors++; $display("[TB] FAIL pp_size1: got %0d expected 4", bus.iq_size); end
    cycle(0, '0, 2, 1'b0, 1'b0);
    checks++; if (bus.out_data !== 64'h00000023_00000022) begin errors++; $display("[TB] FAIL pp_data2: got %h expected 0000002300000022", bus.out_data); end
    cycle(0, '0, 2, 1'b0, 1'b0);
    checks++; if (bus.iq_size !== 4'd0) begin errors++; $display("[TB] FAIL pp_empty: got %0d expected 0", bus.iq_size); end
    checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("[TB] FAIL pp_valid: got %b expected 00", bus.out_valid); end
    checks++; if (high_water !== 4'd6) begin errors++; $display("[TB] FAIL pp_hw: got %0d expected 6", high_water); end
  endtask

  task automatic test_overflow_wrap;
    cycle(4, pack4(32'h30, 32'h31, 32'h32, 32'h33), 0, 1'b0, 1'b0);
    cycle(2, pack4(32'h34, 32'h35, 32'h0, 32'h0), 0, 1'b0, 1'b0);
    checks++; if (bus.iq_size !== 4'd6) begin errors++; $display("[TB] FAIL ovf_fill: got %0d expected 6", bus.iq_size); end
    cycle(4, pack4(32'h40, 32'h41, 32'h42, 32'h43), 0, 1'b0, 1'b0);
    checks++; if (bus.iq_size !== 4'd6) begin errors++; $display("[TB] FAIL ovf_size: got %0d expected 6", bus.iq_size); end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow_err); end
    checks++; if (bus.out_data !== 64'h00000031_00000030) begin errors++; $display("[TB] FAIL ovf_data: got %h expected 0000003100000030", bus.out_data); end
    cycle(2, pack4(32'h36, 32'h37, 32'h0, 32'h0), 0, 1'b0, 1'b0);
    checks++; if (bus.iq_size_left !== 4'd0) begin errors++; $display("[TB] FAIL full_left: got %0d expected 0", bus.iq_size_left); end
    // Full: pop 2 + push 2 must reject the push.
    cycle(2, pack4(32'h50, 32'h51, 32'h0, 32'h0), 2, 1'b0, 1'b0);
    checks++; if (bus.iq_size !== 4'd6) begin errors++; $display("[TB] FAIL full_pp_size: got %0d expected 6", bus.iq_size); end
    checks++; if (bus.out_data !== 64'h00000033_00000032) begin errors++; $display("[TB] FAIL full_pp_data: got %h expected 0000003300000032", bus.out_data); end
    cycle(2, pack4(32'h50, 32'h51, 32'h0, 32'h0), 2, 1'b0, 1'b0);
    checks++; if (bus.out_data !== 64'h00000035_00000034) begin errors++; $display("[TB] FAIL wrap_data0: got %h expected 0000003500000034", bus.out_data); end
    cycle(2, pack4(32'h52, 32'h53, 32'h0, 32'h0), 2, 1'b0, 1'b0);
    checks++; if (bus.out_data !== 64'h00000037_00000036) begin errors++; $display("[TB] FAIL wrap_data1: got %h expected 0000003700000036", bus.out_data); end
    checks++; if (bus.iq_size !== 4'd6) begin errors++; $display("[TB] FAIL wrap_size: got %0d expected 6", bus.iq_size); end
    cycle(0, '0, 2, 1'b0, 1'b0);
    checks++; if (bus.out_data !== 64'h00000051_00000050) begin errors++; $display("[TB] FAIL wrap_data2: got %h expected 0000005100000050", bus.out_data); end
    cycle(0, '0, 2, 1'b0, 1'b0);
    checks++; if (bus.out_data !== 64'h00000053_00000052) begin errors++; $display("[TB] FAIL wrap_data3: got %h expected 0000005300000052", bus.out_data); end
    cycle(0, '0, 2, 1'b0, 1'b0);
    checks++; if (bus.iq_size !== 4'd0) begin errors++; $display("[TB] FAIL wrap_empty: got %0d expected 0", bus.iq_size); end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow_err); end
    checks++; if (high_water !== 4'd8) begin errors++; $display("[TB] FAIL ovf_hw: got %0d expected 8", high_water); end
  endtask

  task automatic test_underflow;
    cycle(1, pack4(32'h60, 32'h0, 32'h0, 32'h0), 0, 1'b0, 1'b0);
    checks++; if (bus.out_valid !== 2'b01) begin errors++; $display("[TB] FAIL unf_valid1: got %b expected 01", bus.out_valid); end
    checks++; if (bus.out_data[31:0] !== 32'h60) begin errors++; $display("[TB] FAIL unf_data: got %h expected 00000060", bus.out_data[31:0]); end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("[TB] FAIL unf_pre: got %b expected 0", underflow_err); end
    cycle(0, '0, 2, 1'b0, 1'b0);
    checks++; if (bus.iq_size !== 4'd0) begin errors++; $display("[TB] FAIL unf_size: got %0d expected 0", bus.iq_size); end
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("[TB] FAIL unf_flag: got %b expected 1", underflow_err); end
    checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("[TB] FAIL unf_valid0: got %b expected 00", bus.out_valid); end
  endtask

  task automatic test_stall_flush;
    cycle(4, pack4(32'h70, 32'h71, 32'h72, 32'h73), 0, 1'b0, 1'b0);
    cycle(1, pack4(32'h74, 32'h0, 32'h0, 32'h0), 0, 1'b0, 1'b0);
    checks++; if (bus.iq_size !== 4'd5) begin errors++; $display("[TB] FAIL sf_fill: got %0d expected 5", bus.iq_size); end
    cycle(3, pack4(32'h80, 32'h81, 32'h82, 32'h0), 2, 1'b1, 1'b0);
    checks++; if (bus.iq_size !== 4'd5) begin errors++; $display("[TB] FAIL stall_size: got %0d expected 5", bus.iq_size); end
    checks++; if (bus.out_data !== 64'h00000071_00000070) begin errors++; $display("[TB] FAIL stall_data: got %h expected 0000007100000070", bus.out_data); end
    cycle(4, pack4(32'h84, 32'h85, 32'h86, 32'h87), 0, 1'b0, 1'b1);
    checks++; if (bus.iq_size !== 4'd0) begin errors++; $display("[TB] FAIL flush_size: got %0d expected 0", bus.iq_size); end
    checks++; if (bus.iq_size_left !== 4'd8) begin errors++; $display("[TB] FAIL flush_left: got %0d expected 8", bus.iq_size_left); end
    checks++; if (high_water !== 4'd0) begin errors++; $display("[TB] FAIL flush_hw: got %0d expected 0", high_water); end
    checks++; if ({overflow_err, underflow_err} !== 2'b11) begin errors++; $display("[TB] FAIL flush_err: got %b expected 11", {overflow_err, underflow_err}); end
    checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("[TB] FAIL flush_valid: got %b expected 00", bus.out_valid); end
    cycle(2, pack4(32'h90, 32'h91, 32'h0, 32'h0), 0, 1'b0, 1'b0);
    checks++; if (bus.out_data !== 64'h00000091_00000090) begin errors++; $display("[TB] FAIL post_flush_data: got %h expected 0000009100000090", bus.out_data); end
    checks++; if (high_water !== 4'd2) begin errors++; $display("[TB] FAIL post_flush_hw: got %0d expected 2", high_water); end
  endtask

  task automatic test_async_reset;
    cycle(4, pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 0, 1'b0, 1'b0);
    checks++; if (bus.iq_size !== 4'd6) begin errors++; $display("[TB] FAIL ar_pre: got %0d expected 6", bus.iq_size); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.iq_size !== 4'd0) begin errors++; $display("[TB] FAIL ar_size: got %0d expected 0", bus.iq_size); end
    checks++; if (bus.iq_size_left !== 4'd8) begin errors++; $display("[TB] FAIL ar_left: got %0d expected 8", bus.iq_size_left); end
    checks++; if (bus.out_data !== 64'h0) begin errors++; $display("[TB] FAIL ar_data: got %h expected 0", bus.out_data); end
    checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("[TB] FAIL ar_valid: got %b expected 00", bus.out_valid); end
    checks++; if ({overflow_err, underflow_err} !== 2'b00) begin errors++; $display("[TB] FAIL ar_err: got %b expected 00", {overflow_err, underflow_err}); end
    checks++; if (high_water !== 4'd0) begin errors++; $display("[TB] FAIL ar_hw: got %0d expected 0", high_water); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Stalled over-pop on an empty queue must not raise underflow.
    cycle(0, '0, 2, 1'b1, 1'b0);
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("[TB] FAIL stall_noerr: got %b expected 0", underflow_err); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_push_basic();
    test_push_pop_order();
    test_overflow_wrap();
    test_underflow();
    test_stall_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_queue_mp.md
Name: issue_queue_mp

Overview:
- Parametrised multi-port circular issue queue between decode and issue; successor to the fixed 4-in/2-out queue.
- Generalised in depth, element width, push width and pop width.
- Adds per-slot output valid bits, a stall hold, and flush priority over push and pop.
- Adds sticky overflow/underflow error flags and an occupancy high-water mark for debug.

Parameters:
- DEPTH, 8, number of entries; power of two, ≥ max(PUSH_W, POP_W).
- ELEM_W, 64, bits per element (packed ISSUE_QUEUE_ELEMENT width).
- PUSH_W, 4, max elements pushed per cycle.
- POP_W, 2, max elements popped per cycle.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all contents.
- stall  in  1  freeze queue state (push and pop ignored).
- in_data  in  PUSH_W*ELEM_W  push elements; slot 0 is oldest.
- in_data_number  in  $clog2(PUSH_W+1)  number of slots of in_data to enqueue.
- out_data  out  POP_W*ELEM_W  head elements; slot 0 = head.
- out_valid  out  POP_W  out_valid[i] = (i < iq_size).
- out_data_number  in  $clog2(POP_W+1)  number of head slots consumed this cycle.
- iq_size  out  $clog2(DEPTH+1)  current occupancy.
- iq_size_left  out  $clog2(DEPTH+1)  DEPTH - iq_size.
- overflow_err  out  1  sticky: push exceeded space.
- underflow_err  out  1  sticky: pop exceeded occupancy.
- high_water  out  $clog2(DEPTH+1)  max iq_size seen since reset/flush.

Behaviour:
- Reset (async, rst_n=0): head=0, tail=0, count=0, storage cleared to 0; out_data=0, out_valid=0, iq_size=0, iq_size_left=DEPTH, both err=0, high_water=0. Takes effect immediately and overrides any operation in flight.
- Pointers: head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH. Push slot k writes mem[(tail+k) mod DEPTH]. out_data[i] = mem[(head+i) mod DEPTH], combinational from registered state.
- Output timing: iq_size, iq_size_left and out_valid derive only from registered count. No combinational path from in_* or out_data_number to any output.
- Latency: an element pushed in cycle N is visible on out_data/out_valid in cycle N+1. There is no same-cycle bypass, including when the queue is empty.
- Pop: eff_pop = min(out_data_number, count). If out_data_number > count, set underflow_err.
- Push: space is judged against start-of-cycle iq_size_left; same-cycle pops do not free space for pushes.
  - If in_data_number ≤ iq_size_left, all slots are written.
  - Otherwise nothing is written and overflow_err is set (all-or-nothing).
- Update: count_next = count - eff_pop + eff_push; head += eff_pop; tail += eff_push.
- Simultaneous push and pop at full or empty follow the rules above. Example: full queue, pop 2, push 2 → push rejected, overflow set, count = DEPTH-2.
- Priority: rst_n > flush > stall > push/pop.
  - flush=1: head=tail=count=0, high_water=0 next cycle; err flags retained; storage contents need not be cleared.
  - stall=1 (no flush): pointers, count, storage and flags hold; inputs ignored; no error flags set.
- high_water: updated to max(high_water, count_next) each non-stalled cycle.
- in_data_number > PUSH_W or out_data_number > POP_W: illegal; behaviour unspecified. The bench asserts these never occur.
- Sticky error flags clear only on reset.

Test Plan (DEPTH=8, PUSH_W=4, POP_W=2, ELEM_W=32):
- Reset, push 4 values 0x10..0x13, pop 0 → next cycle iq_size=4, size_left=4, out_data={0x11,0x10}, out_valid=2'b11.
- Pop 2 and push 4 (0x20..0x23) in the same cycle → iq_size=6, out_data slot0=0x12; after 3 more pop-2 cycles the queue is empty, out_valid=0, and the order is 0x12,0x13,0x20..0x23 with correct wrap.
- Fill to 6, then push 4 → rejected, iq_size stays 6, overflow_err=1 and stays 1 through later traffic.
- iq_size=1, out_data_number=2 → one element popped, iq_size=0, underflow_err=1.
- Fill to 5 with stall=1 plus push 3 / pop 2 → no change; then flush together with push → iq_size=0, size_left=8, high_water=0, err flags unchanged.
- Push 4 then assert rst_n=0 mid-cycle → outputs go to reset values before the next clk edge.
